nway_mux_pipe_reg: RTL and testbench

//  Registered M-input, N-bit selector stage with valid/ready handshake and 2-entry skid buffer.

---
 rtl/mux_pipe_pkg.sv | 17 +
 rtl/nbit_nx1_mux.sv | 27 ++
 rtl/nway_mux_pipe_reg.sv | 128 ++++++++++++
 tb/tb_nway_mux_pipe_reg.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mux_pipe_pkg.sv
// Shared definitions for the registered N-way selector stage.
//   state_t   : occupancy encoding (EMPTY, ONE, FULL)
//   sel_width : select width for an M-input mux, at least one bit
package mux_pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    // A 2:1 mux still needs one select bit, so never return zero.
    function automatic int sel_width(input int m);
        return (m > 2) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/nbit_nx1_mux.sv
// Purely combinational M:1 selector of N-bit words.
// Ports:
//   in_flat_i : M*N packed inputs, input k = in_flat_i[k*N +: N]
//   sel_i     : select, values >= M produce all-zero data
//   data_o    : selected word
module nbit_nx1_mux
    import mux_pipe_pkg::*;
#(
    parameter int N = 32,
    parameter int M = 4
) (
    input  logic [M*N-1:0]          in_flat_i,
    input  logic [sel_width(M)-1:0] sel_i,
    output logic [N-1:0]            data_o
);

    // Zero default covers out-of-range selects when M is not a power of 2.
    always_comb begin
        data_o = '0;
        for (int k = 0; k < M; k++) begin
            if (int'(sel_i) == k) begin
                data_o = in_flat_i[k*N +: N];
            end
        end
    end

endmodule

// File: rtl/nway_mux_pipe_reg.sv
// Registered M-input, N-bit selector stage with valid/ready handshake and a
// 2-entry skid buffer (head + skid). Full throughput with out_ready held high.
// Optional feature macro: NWAY_MUX_SEL_CHECK_EN enables the sticky sel_err
// out-of-range flag; without it sel_err is tied low.
// Ports:
//   clk, rst              : rising-edge clock, asynchronous active-high reset
//   in_flat, sel          : M*N packed inputs and select, sampled on in_fire
//   in_valid / in_ready   : upstream handshake, in_ready depends on state only
//   flush                 : synchronous discard of all held entries
//   out_data, out_sel     : head entry data and the select it was captured with
//   out_valid / out_ready : downstream handshake
//   sel_err               : sticky out-of-range select flag
//   dbg_state             : current occupancy state for observation
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; the producer holds data stable while valid & !ready.
module nway_mux_pipe_reg
    import mux_pipe_pkg::*;
#(
    parameter int N = 32,
    parameter int M = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [M*N-1:0]          in_flat,
    input  logic [sel_width(M)-1:0] sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [N-1:0]            out_data,
    output logic [sel_width(M)-1:0] out_sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err,
    output logic [1:0]              dbg_state
);

    localparam int SEL_W = sel_width(M);

    state_t             state_q;
    logic [N-1:0]       head_data_q, skid_data_q;
    logic [SEL_W-1:0]   head_sel_q,  skid_sel_q;
    logic [N-1:0]       mux_data;
    logic               in_fire, out_fire;

    nbit_nx1_mux #(.N(N), .M(M)) u_mux (
        .in_flat_i (in_flat),
        .sel_i     (sel),
        .data_o    (mux_data)
    );

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = head_data_q;
    assign out_sel   = head_sel_q;
    assign dbg_state = state_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            head_data_q <= '0;
            head_sel_q  <= '0;
            skid_data_q <= '0;
            skid_sel_q  <= '0;
        end else if (flush) begin
            // Flush wins over any same-cycle transfer; nothing is emitted.
            state_q     <= EMPTY;
            head_data_q <= '0;
            head_sel_q  <= '0;
            skid_data_q <= '0;
            skid_sel_q  <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_q     <= ONE;
                        head_data_q <= mux_data;
                        head_sel_q  <= sel;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        head_data_q <= mux_data;
                        head_sel_q  <= sel;
                    end else if (in_fire) begin
                        state_q     <= FULL;
                        skid_data_q <= mux_data;
                        skid_sel_q  <= sel;
                    end else if (out_fire) begin
                        state_q     <= EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the drain path exists.
                    if (out_fire) begin
                        state_q     <= ONE;
                        head_data_q <= skid_data_q;
                        head_sel_q  <= skid_sel_q;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

`ifdef NWAY_MUX_SEL_CHECK_EN
    logic sel_oor;
    logic sel_err_q;

    assign sel_oor = ({1'b0, sel} >= (SEL_W+1)'(M));

    // Sticky until reset; flush deliberately leaves it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_err_q <= 1'b0;
        end else if (in_fire && sel_oor) begin
            sel_err_q <= 1'b1;
        end
    end

    assign sel_err = sel_err_q;
`else
    assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_nway_mux_pipe_reg.sv
module tb_nway_mux_pipe_reg;

`ifdef NWAY_MUX_SEL_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT A: N=32, M=4 ----------------
    logic [127:0] in_flat;
    logic [1:0]   sel;
    logic         in_valid, in_ready, flush;
    logic [31:0]  out_data;
    logic [1:0]   out_sel;
    logic         out_valid, out_ready, sel_err;
    logic [1:0]   dbg_state;

    nway_mux_pipe_reg #(.N(32), .M(4)) u_dut (
        .clk(clk), .rst(rst), .in_flat(in_flat), .sel(sel),
        .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
        .out_ready(out_ready), .sel_err(sel_err), .dbg_state(dbg_state)
    );

    // ---------------- DUT B: N=8, M=3 ----------------
    logic [23:0] in_flat3;
    logic [1:0]  sel3;
    logic        in_valid3, in_ready3, flush3;
    logic [7:0]  out_data3;
    logic [1:0]  out_sel3;
    logic        out_valid3, out_ready3, sel_err3;
    logic [1:0]  dbg_state3;

    nway_mux_pipe_reg #(.N(8), .M(3)) u_dut3 (
        .clk(clk), .rst(rst), .in_flat(in_flat3), .sel(sel3),
        .in_valid(in_valid3), .in_ready(in_ready3), .flush(flush3),
        .out_data(out_data3), .out_sel(out_sel3), .out_valid(out_valid3),
        .out_ready(out_ready3), .sel_err(sel_err3), .dbg_state(dbg_state3)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance one edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] word_set(input int w);
        logic [127:0] v;
        for (int k = 0; k < 4; k++) v[k*32 +: 32] = {8'(w), 8'(k), 16'hA5A5};
        return v;
    endfunction

    task automatic push(input logic [127:0] v, input logic [1:0] s);
        in_flat  = v;
        sel      = s;
        in_valid = 1'b1;
    endtask

    initial begin
        in_flat = '0; sel = '0; in_valid = 0; flush = 0; out_ready = 0;
        in_flat3 = '0; sel3 = '0; in_valid3 = 0; flush3 = 0; out_ready3 = 0;

        // ---- reset values ----
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data",  out_data, 0);
        check("rst_out_sel",   out_sel, 0);
        check("rst_in_ready",  in_ready, 1);
        check("rst_sel_err",   sel_err, 0);
        check("rst_state",     dbg_state, 0);
        #5 rst = 1'b0;   // t=7, between edges

        // ---- single transfer ----
        tick();
        out_ready = 1'b1;
        push({32'h44444444, 32'hDEADBEEF, 32'h22222222, 32'h11111111}, 2'd2);
        tick();
        check("one_valid", out_valid, 1);
        check("one_data",  out_data, 32'hDEADBEEF);
        check("one_sel",   out_sel, 2);
        in_valid = 1'b0;
        tick();
        check("one_drained", out_valid, 0);

        // ---- streaming 8 words, sel cycles 0..3 ----
        for (int i = 0; i < 8; i++) exp_q.push_back({8'(i), 8'(i % 4), 16'hA5A5});
        for (int i = 0; i < 8; i++) begin
            push(word_set(i), 2'(i % 4));
            check("stream_in_ready", in_ready, 1);
            tick();
            check("stream_valid", out_valid, 1);
            check("stream_data", out_data, exp_q.pop_front());
            check("stream_sel", out_sel, 64'(i % 4));
        end
        in_valid = 1'b0;
        tick();
        check("stream_end", out_valid, 0);

        // ---- backpressure: 3 pushes, 2 accepted ----
        out_ready = 1'b0;
        push(128'h0, 2'd0); in_flat[31:0]   = 32'h000000A1; tick();
        check("bp_a_state",  dbg_state, 1);
        check("bp_a_ready",  in_ready, 1);
        push(128'h0, 2'd1); in_flat[63:32]  = 32'h000000B2; tick();
        check("bp_b_state",  dbg_state, 2);
        check("bp_b_ready",  in_ready, 0);
        push(128'h0, 2'd3); in_flat[127:96] = 32'h000000C3; tick();
        check("bp_c_refused", dbg_state, 2);
        check("bp_hold_data", out_data, 32'hA1);
        check("bp_hold_sel",  out_sel, 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_drain_b_data",  out_data, 32'hB2);
        check("bp_drain_b_sel",   out_sel, 1);
        check("bp_drain_b_ready", in_ready, 1);
        tick();
        check("bp_drain_empty", out_valid, 0);

        // ---- flush while FULL ----
        out_ready = 1'b0;
        push(word_set(9), 2'd1); tick();
        push(word_set(10), 2'd2); tick();
        check("fl_full", dbg_state, 2);
        flush = 1'b1; out_ready = 1'b1; push(word_set(11), 2'd3);
        tick();
        check("fl_valid", out_valid, 0);
        check("fl_data",  out_data, 0);
        check("fl_ready", in_ready, 1);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        check("fl_no_emit", out_valid, 0);

        // ---- M=3: in-range then out-of-range select ----
        out_ready3 = 1'b1;
        in_flat3 = {8'h33, 8'h22, 8'h11};
        sel3 = 2'd1; in_valid3 = 1'b1;
        tick();
        check("m3_data", out_data3, 8'h22);
        check("m3_err0", sel_err3, 0);
        sel3 = 2'd3;
        tick();
        check("m3_oor_data",  out_data3, 0);
        check("m3_oor_sel",   out_sel3, 3);
        check("m3_oor_valid", out_valid3, 1);
        in_valid3 = 1'b0;
        tick();
        check("m3_err_set", sel_err3, 64'(EXP_ERR));
        flush3 = 1'b1;
        tick();
        flush3 = 1'b0;
        check("m3_err_after_flush", sel_err3, 64'(EXP_ERR));
        check("m3_flush_valid", out_valid3, 0);
        check("m4_err_never", sel_err, 0);

        // ---- asynchronous reset mid-stream ----
        push(word_set(5), 2'd0);
        in_valid3 = 1'b1; sel3 = 2'd0;
        tick();
        check("ar_pre_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("ar_valid",  out_valid, 0);
        check("ar_ready",  in_ready, 1);
        check("ar_data",   out_data, 0);
        check("ar_err3",   sel_err3, 0);
        check("ar_valid3", out_valid3, 0);
        in_valid = 1'b0; in_valid3 = 1'b0;
        #2 rst = 1'b0;
        tick();
        check("ar_after", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
